// File: rtl/engine_ctrl_pkg.sv
// engine_ctrl_pkg: shared state encoding, job record and defaults for the engine job controller
package engine_ctrl_pkg;
  localparam int DEF_N_IN = 2;
  localparam int DEF_N_OUT = 1;
  localparam int DEF_LEN_W = 16;
  localparam int DEF_TAG_W = 4;
  localparam logic [31:0] TO_MAX = '1;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_START,
    S_RUN,
    S_FLUSH,
    S_DONE,
    S_ERR
  } ctrl_state_e;
  typedef struct packed {
    logic [DEF_N_IN*DEF_LEN_W-1:0]  len_in;
    logic [DEF_N_OUT*DEF_LEN_W-1:0] len_out;
    logic [DEF_TAG_W-1:0]           tag;
  } job_req_t;
endpackage

// File: rtl/engine_watchdog_cnt.sv
// engine_watchdog_cnt: saturating stall counter, cleared or kicked to zero, expires at all-ones
module engine_watchdog_cnt
  import engine_ctrl_pkg::*;
#(
  parameter int TO_W = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic kick_i,
  output logic expire_o
);
  logic [TO_W-1:0] r_cnt;
  assign expire_o = r_cnt == TO_MAX[TO_W-1:0];
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_cnt <= '0;
    else if (clr_i | kick_i) r_cnt <= '0;
    else if (!expire_o) r_cnt <= r_cnt + TO_W'(1);
endmodule

// File: rtl/engine_job_ctrl.sv
// engine_job_ctrl: accepts one job at a time, launches streamers and engine, and reports
// completion or watchdog timeout with the job tag.
module engine_job_ctrl
  import engine_ctrl_pkg::*;
#(
  parameter int N_IN  = DEF_N_IN,
  parameter int N_OUT = DEF_N_OUT,
  parameter int LEN_W = DEF_LEN_W,
  parameter int TAG_W = DEF_TAG_W,
  parameter int TO_W  = 20
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   job_valid_i,
  output logic                   job_ready_o,
  input  logic [N_IN*LEN_W-1:0]  job_len_in_i,
  input  logic [N_OUT*LEN_W-1:0] job_len_out_i,
  input  logic [TAG_W-1:0]       job_tag_i,
  output logic [N_IN-1:0]        src_start_o,
  output logic [N_OUT-1:0]       snk_start_o,
  input  logic [N_IN-1:0]        src_done_i,
  input  logic [N_OUT-1:0]       snk_done_i,
  output logic                   eng_start_o,
  output logic [N_IN*LEN_W-1:0]  eng_max_in_o,
  output logic [N_OUT*LEN_W-1:0] eng_max_out_o,
  input  logic                   eng_done_i,
  input  logic                   eng_idle_i,
  input  logic                   hs_any_i,
  output logic                   busy_o,
  output logic                   evt_done_o,
  output logic [TAG_W-1:0]       evt_tag_o,
  output logic                   err_timeout_o
);
  ctrl_state_e      r_state;
  logic [TAG_W-1:0] r_tag;
  logic             r_eng_seen;
  logic             w_zero;
  logic             w_eng;
  logic             w_run_ok;
  logic             w_active;
  logic             w_wd_clr;
  logic             w_expire;
  logic             w_unused_idle;
  assign job_ready_o   = r_state == S_IDLE;
  assign busy_o        = r_state != S_IDLE;
  assign w_unused_idle = eng_idle_i;
  // engine done may be a single-cycle pulse, so remember it until the sources finish
  assign w_eng    = eng_done_i | r_eng_seen;
  assign w_run_ok = w_eng & (&src_done_i);
  assign w_active = (r_state == S_RUN) | (r_state == S_FLUSH);
  assign w_wd_clr = clear_i | ~w_active | ((r_state == S_RUN) & w_run_ok);
  always_comb begin
    w_zero = 1'b0;
    for (int k = 0; k < N_IN; k++) w_zero = w_zero | ~|job_len_in_i[k*LEN_W +: LEN_W];
    for (int k = 0; k < N_OUT; k++) w_zero = w_zero | ~|job_len_out_i[k*LEN_W +: LEN_W];
  end
  engine_watchdog_cnt #(.TO_W(TO_W)) u_wd (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (w_wd_clr),
    .kick_i  (hs_any_i),
    .expire_o(w_expire)
  );
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_tag         <= '0;
      r_eng_seen    <= 1'b0;
      src_start_o   <= '0;
      snk_start_o   <= '0;
      eng_start_o   <= 1'b0;
      eng_max_in_o  <= '0;
      eng_max_out_o <= '0;
      evt_done_o    <= 1'b0;
      evt_tag_o     <= '0;
      err_timeout_o <= 1'b0;
    end else begin
      src_start_o <= '0;
      snk_start_o <= '0;
      eng_start_o <= 1'b0;
      evt_done_o  <= 1'b0;
      if (clear_i) begin
        r_state       <= S_IDLE;
        r_eng_seen    <= 1'b0;
        err_timeout_o <= 1'b0;
      end else
        case (r_state)
          S_IDLE:
            if (job_valid_i) begin
              eng_max_in_o  <= job_len_in_i;
              eng_max_out_o <= job_len_out_i;
              r_tag         <= job_tag_i;
              r_eng_seen    <= 1'b0;
              err_timeout_o <= 1'b0;
              if (w_zero) begin
                r_state    <= S_DONE;
                evt_done_o <= 1'b1;
                evt_tag_o  <= job_tag_i;
              end else begin
                r_state     <= S_LAUNCH;
                src_start_o <= '1;
                snk_start_o <= '1;
              end
            end
          S_LAUNCH: begin
            r_state     <= S_START;
            eng_start_o <= 1'b1;
          end
          S_START: r_state <= S_RUN;
          S_RUN: begin
            if (eng_done_i) r_eng_seen <= 1'b1;
            if (w_run_ok) begin
              r_state    <= &snk_done_i ? S_DONE : S_FLUSH;
              evt_done_o <= &snk_done_i;
              evt_tag_o  <= &snk_done_i ? r_tag : evt_tag_o;
            end else if (w_expire) begin
              r_state       <= S_ERR;
              err_timeout_o <= 1'b1;
              evt_done_o    <= 1'b1;
              evt_tag_o     <= r_tag;
            end
          end
          S_FLUSH:
            if (&snk_done_i) begin
              r_state    <= S_DONE;
              evt_done_o <= 1'b1;
              evt_tag_o  <= r_tag;
            end else if (w_expire) begin
              r_state       <= S_ERR;
              err_timeout_o <= 1'b1;
              evt_done_o    <= 1'b1;
              evt_tag_o     <= r_tag;
            end
          default: r_state <= S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_engine_job_ctrl.sv
// tb_engine_job_ctrl: directed jobs against a streamer/engine model; events checked from a queue
module tb_engine_job_ctrl;
  localparam int N_IN = 2, N_OUT = 1, LEN_W = 16, TAG_W = 4, TO_W = 4;
  logic clk = 0, rst_i = 1, clear_i = 0, job_valid_i = 0, job_ready_o;
  logic [N_IN*LEN_W-1:0] job_len_in_i = '0, eng_max_in_o;
  logic [N_OUT*LEN_W-1:0] job_len_out_i = '0, eng_max_out_o;
  logic [TAG_W-1:0] job_tag_i = '0, evt_tag_o;
  logic [N_IN-1:0] src_start_o, src_done_i = '0;
  logic [N_OUT-1:0] snk_start_o, snk_done_i = '0;
  logic eng_start_o, eng_done_i = 0, eng_idle_i = 0, hs_any_i = 0;
  logic busy_o, evt_done_o, err_timeout_o;
  int checks = 0, errors = 0, cyc = 0;
  int src_lag = 1, snk_lag = 1, eng_lag = 1, src_c = 0, snk_c = 0, eng_c = 0;
  int src_pulses = 0, snk_pulses = 0, eng_pulses = 0, src_cyc = 0, eng_cyc = 0;
  int evt_cnt = 0, evt_cyc = 0, acc_cyc = 0;
  logic [TAG_W:0] exp_q[$];

  engine_job_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .LEN_W(LEN_W), .TAG_W(TAG_W), .TO_W(TO_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .job_valid_i(job_valid_i),
    .job_ready_o(job_ready_o), .job_len_in_i(job_len_in_i), .job_len_out_i(job_len_out_i),
    .job_tag_i(job_tag_i), .src_start_o(src_start_o), .snk_start_o(snk_start_o),
    .src_done_i(src_done_i), .snk_done_i(snk_done_i), .eng_start_o(eng_start_o),
    .eng_max_in_o(eng_max_in_o), .eng_max_out_o(eng_max_out_o), .eng_done_i(eng_done_i),
    .eng_idle_i(eng_idle_i), .hs_any_i(hs_any_i), .busy_o(busy_o), .evt_done_o(evt_done_o),
    .evt_tag_o(evt_tag_o), .err_timeout_o(err_timeout_o));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Streamer/engine model: done drops on start, rises lag negedges later (lag 0 = never).
  always @(negedge clk) begin
    if (src_start_o != '0) begin
      src_pulses++; src_cyc = cyc; src_done_i = '0; src_c = src_lag;
    end else if (src_c > 0) begin
      src_c--; if (src_c == 0) src_done_i = '1;
    end
    if (snk_start_o != '0) begin
      snk_pulses++; snk_done_i = '0; snk_c = snk_lag;
    end else if (snk_c > 0) begin
      snk_c--; if (snk_c == 0) snk_done_i = '1;
    end
    if (eng_start_o) begin
      eng_pulses++; eng_cyc = cyc; eng_done_i = 0; eng_c = eng_lag;
    end else if (eng_c > 0) begin
      eng_c--; if (eng_c == 0) eng_done_i = 1;
    end
  end

  // Monitor: every completion event is compared against the oldest expected {tag, err}.
  always @(negedge clk) if (!rst_i && evt_done_o) begin
    evt_cnt++; evt_cyc = cyc;
    if (exp_q.size() == 0) chk("unexpected_event", 32'(evt_tag_o), 32'hFFFF);
    else begin
      logic [TAG_W:0] e;
      e = exp_q.pop_front();
      chk("evt_tag", 32'(evt_tag_o), 32'(e[TAG_W-1:0]));
      chk("evt_err", 32'(err_timeout_o), 32'(e[TAG_W]));
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] o,
                      input logic [TAG_W-1:0] t, input logic err);
    int n = 0;
    job_len_in_i = {b, a}; job_len_out_i = o; job_tag_i = t; job_valid_i = 1;
    while (!job_ready_o && n < 200) begin @(negedge clk); n++; end
    chk("accept_wait", 32'(job_ready_o), 1);
    exp_q.push_back({err, t});
    acc_cyc = cyc;
    @(negedge clk);
    job_valid_i = 0;
  endtask

  task automatic wait_evt(input int target);
    int n = 0;
    while (evt_cnt < target && n < 200) begin @(negedge clk); n++; end
    chk("event_count", 32'(evt_cnt), 32'(target));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int acc1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_evt", 32'(evt_done_o), 0);
    chk("rst_err", 32'(err_timeout_o), 0);
    chk("rst_starts", 32'({src_start_o, snk_start_o, eng_start_o}), 0);
    chk("rst_max", 32'(eng_max_in_o | 32'(eng_max_out_o)), 0);
    rst_i = 0;
    @(negedge clk);
    chk("idle_ready", 32'(job_ready_o), 1);

    // Basic job: instant dones, 4-cycle gap accept->event (5 cycles inclusive).
    src_pulses = 0; snk_pulses = 0; eng_pulses = 0;
    src_lag = 1; snk_lag = 1; eng_lag = 1;
    send(8, 8, 8, 3, 0);
    chk("max_in", eng_max_in_o, {16'd8, 16'd8});
    chk("max_out", 32'(eng_max_out_o), 8);
    chk("busy", 32'(busy_o), 1);
    wait_evt(1);
    chk("src_pulses", src_pulses, 1);
    chk("snk_pulses", snk_pulses, 1);
    chk("eng_pulses", eng_pulses, 1);
    chk("eng_after_src", eng_cyc - src_cyc, 1);
    chk("basic_latency", evt_cyc - acc_cyc, 4);

    // Sink done lags engine done by 20 cycles; streams keep handshaking.
    hs_any_i = 1; snk_lag = 22;
    send(16, 4, 32, 9, 0);
    wait_evt(2);
    chk("flush_latency", evt_cyc - acc_cyc, 24);

    // No handshakes, engine never finishes: watchdog expires after 15 stall cycles in RUN.
    hs_any_i = 0; snk_lag = 1; eng_lag = 0;
    send(2, 2, 2, 12, 1);
    wait_evt(3);
    chk("timeout_latency", evt_cyc - eng_cyc, 17);
    chk("err_sticky", 32'(err_timeout_o), 1);

    // Zero-length job: bypass, event the cycle after accept, err cleared by accept.
    src_pulses = 0; snk_pulses = 0; eng_pulses = 0; eng_lag = 1;
    send(4, 4, 0, 5, 0);
    wait_evt(4);
    chk("zero_latency", evt_cyc - acc_cyc, 1);
    chk("zero_starts", src_pulses + snk_pulses + eng_pulses, 0);

    // Clear in RUN: back to IDLE, no event, lengths held.
    hs_any_i = 1; eng_lag = 0;
    send(7, 6, 5, 10, 0);
    void'(exp_q.pop_back());
    repeat (4) @(negedge clk);
    chk("pre_clear_busy", 32'(busy_o), 1);
    clear_i = 1;
    @(negedge clk);
    clear_i = 0;
    chk("clear_busy", 32'(busy_o), 0);
    chk("clear_ready", 32'(job_ready_o), 1);
    chk("clear_starts", 32'({src_start_o, snk_start_o, eng_start_o}), 0);
    chk("clear_max_held", eng_max_in_o, {16'd6, 16'd7});
    repeat (5) @(negedge clk);
    chk("clear_no_event", evt_cnt, 4);
    eng_lag = 1; hs_any_i = 0;
    send(3, 3, 3, 7, 0);
    wait_evt(5);
    chk("post_clear_latency", evt_cyc - acc_cyc, 4);

    // Back-to-back with valid held: second accept only once IDLE again.
    job_len_in_i = {16'd8, 16'd8}; job_len_out_i = 8; job_tag_i = 1; job_valid_i = 1;
    exp_q.push_back({1'b0, 4'd1});
    acc1 = cyc;
    @(negedge clk);
    job_tag_i = 2;
    exp_q.push_back({1'b0, 4'd2});
    begin
      int n = 0;
      while (!job_ready_o && n < 200) begin @(negedge clk); n++; end
    end
    chk("b2b_second_accept", cyc - acc1, 5);
    @(negedge clk);
    job_valid_i = 0;
    wait_evt(7);
    chk("b2b_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule
